// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the key session controller: FSM state encoding,
// request owner encoding and default timing parameters.
package key_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_LATCH     = 3'd4
    } ctrl_state_t;

    typedef enum logic [1:0] {
        OWN_AUTO = 2'd0,
        OWN_TX   = 2'd1,
        OWN_RX   = 2'd2
    } owner_t;

    localparam int REKEY_FRAMES_DEF   = 16;
    localparam int TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   req[0]=TX, req[1]=RX; gnt_onehot is combinational.
//   advance: a selection is being taken this cycle. The pointer only moves
//   when both paths were requesting, so a lone requester never steals the
//   tie-break bias from the other path.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt_onehot
);

    logic ptr;  // 0: TX wins ties, 1: RX wins ties

    always_comb begin
        gnt_onehot = req;
        if (req == 2'b11)
            gnt_onehot = ptr ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (advance && req == 2'b11)
            ptr <= gnt_onehot[0];  // TX just won -> favour RX next
    end

endmodule

// File: rtl/key_session_ctrl.sv
// Key session controller: shares the LFSR keygen between UART TX and RX.
// Arbitrates TX/RX requests plus an internal auto-rekey, issues a single
// generate pulse, follows the keygen busy/key_valid handshake and latches
// the finished key into the session registers, pulsing the owner's grant.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   tx_req, rx_req       level requests, held until the matching grant
//   frame_done           one pulse per UART frame (drives auto-rekey)
//   kg_busy/kg_key_valid keygen handshake; kg_aes_key/kg_crc_key key data
//   kg_generate          one-cycle start pulse to the keygen
//   tx_gnt, rx_gnt       one-cycle grant pulses, coincident with key update
//   session_*_key        latched keys; session_valid after first latch
//   key_epoch            successful latch count (wraps)
//   ctrl_busy            high outside IDLE
//   timeout_err          sticky abort flag, cleared by the next latch
module key_session_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int REKEY_FRAMES   = REKEY_FRAMES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int EPOCH_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tx_req,
    input  logic               rx_req,
    input  logic               frame_done,
    input  logic               kg_busy,
    input  logic               kg_key_valid,
    input  logic [127:0]       kg_aes_key,
    input  logic [15:0]        kg_crc_key,
    output logic               kg_generate,
    output logic               tx_gnt,
    output logic               rx_gnt,
    output logic [127:0]       session_aes_key,
    output logic [15:0]        session_crc_key,
    output logic               session_valid,
    output logic [EPOCH_W-1:0] key_epoch,
    output logic               ctrl_busy,
    output logic               timeout_err
);

    localparam int FCW = (REKEY_FRAMES > 1) ? $clog2(REKEY_FRAMES + 1) : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] TMO_RELOAD = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(REKEY_FRAMES - 1);

    ctrl_state_t    state;
    owner_t         owner;
    logic [FCW-1:0] frame_cnt;
    logic           auto_pend;
    logic [TCW-1:0] tmo_cnt;
    logic [1:0]     arb_gnt;
    logic           arb_adv;

    // Selection only happens in IDLE and AUTO pre-empts the TX/RX arbiter.
    assign arb_adv = (state == ST_IDLE) && !auto_pend && (tx_req || rx_req);

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        ({rx_req, tx_req}),
        .advance    (arb_adv),
        .gnt_onehot (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            owner           <= OWN_AUTO;
            frame_cnt       <= '0;
            auto_pend       <= 1'b0;
            tmo_cnt         <= '0;
            kg_generate     <= 1'b0;
            tx_gnt          <= 1'b0;
            rx_gnt          <= 1'b0;
            session_aes_key <= '0;
            session_crc_key <= '0;
            session_valid   <= 1'b0;
            key_epoch       <= '0;
            ctrl_busy       <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            kg_generate <= 1'b0;
            tx_gnt      <= 1'b0;
            rx_gnt      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (auto_pend || tx_req || rx_req) begin
                        if (auto_pend)       owner <= OWN_AUTO;
                        else if (arb_gnt[0]) owner <= OWN_TX;
                        else                 owner <= OWN_RX;
                        kg_generate <= 1'b1;
                        ctrl_busy   <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt <= TMO_RELOAD;
                    state   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // key_valid is still high from the previous key here;
                    // only busy rising proves the keygen took the request.
                    if (kg_busy) begin
                        tmo_cnt <= TMO_RELOAD;
                        state   <= ST_WAIT_DONE;
                    end else if (tmo_cnt == '0) begin
                        timeout_err <= 1'b1;
                        ctrl_busy   <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    // Capture on the transition so the grant and the new key
                    // are visible together during the LATCH cycle.
                    if (!kg_busy && kg_key_valid) begin
                        session_aes_key <= kg_aes_key;
                        session_crc_key <= kg_crc_key;
                        session_valid   <= 1'b1;
                        key_epoch       <= key_epoch + 1'b1;
                        timeout_err     <= 1'b0;
                        tx_gnt          <= (owner == OWN_TX);
                        rx_gnt          <= (owner == OWN_RX);
                        if (owner == OWN_AUTO) auto_pend <= 1'b0;
                        state <= ST_LATCH;
                    end else if (tmo_cnt == '0) begin
                        timeout_err <= 1'b1;
                        ctrl_busy   <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ST_LATCH: begin
                    ctrl_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    ctrl_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase

            // Placed after the FSM so a new auto request set in the same
            // cycle as an AUTO latch is not lost.
            if (REKEY_FRAMES != 0 && frame_done) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    auto_pend <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule
